stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 10_000_000, clk cycles per sec_pulse; legal range 2..2^26.
REQ-002 Parameter DB_CYCLES, default 200_000, consecutive stable cycles needed to accept a button level; legal range 1..2^20.
REQ-003 clk  input  1  single system clock; all flops on rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 btn_startstop  input  1  raw asynchronous start/stop push-button, active-high.
REQ-006 btn_clear  input  1  raw asynchronous clear push-button, active-high.
REQ-007 btn_lap  input  1  raw asynchronous lap push-button, active-high.
REQ-008 state  output  3  one-hot mode to the BCD counter: IDLE=3'b100, CLEAR=3'b010, RUNNING=3'b001.
REQ-009 sec_pulse  output  1  one-cycle count strobe to the BCD counter.
REQ-010 lap_hold  output  1  high = display freezes the last shown time while counting continues.
REQ-011 running  output  1  status LED, equals (state == RUNNING).

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, a debouncer and a rising-edge detector, yielding a one-cycle press pulse.
REQ-013 Debouncer: the accepted level SHALL update only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any mismatch break restarts the count at 0.
REQ-014 Press pulse latency: raw rise first sampled at edge k, held stable -> the FSM SHALL act on edge k+DB_CYCLES+3; release SHALL generate no pulse.
REQ-015 FSM IDLE: startstop press -> RUNNING; clear press -> CLEAR; simultaneous startstop and clear -> CLEAR.
REQ-016 FSM RUNNING: startstop press -> IDLE; clear press SHALL be ignored.
REQ-017 FSM CLEAR: SHALL last exactly one cycle, then IDLE unconditionally; presses arriving during CLEAR SHALL be dropped.
REQ-018 state SHALL always be one of the three legal codes; an illegal code SHALL recover to IDLE on the next edge.
REQ-019 Prescaler: the counter counts 0..DIV-1, advances only in RUNNING and holds in IDLE, so the fractional second survives a pause; it SHALL be zeroed in CLEAR.
REQ-020 sec_pulse SHALL be high for exactly the one cycle in which the prescaler is at DIV-1 and state is RUNNING; the prescaler then wraps to 0.
REQ-021 The first sec_pulse after IDLE->RUNNING from a cleared prescaler SHALL occur DIV cycles after the edge that entered RUNNING.
REQ-022 RUNNING->IDLE on the same edge the prescaler would wrap SHALL suppress that wrap; sec_pulse is not asserted in that cycle.
REQ-023 lap_hold SHALL toggle on each lap press in RUNNING, be held in IDLE, and be forced to 0 in CLEAR.
REQ-024 sec_pulse and state SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-025 On nrst low, all outputs SHALL take these values asynchronously and hold them while nrst is low: state=IDLE, sec_pulse=0, lap_hold=0, running=0.
REQ-026 On nrst low, prescaler, debounce counters, accepted levels and synchronizers SHALL reset to 0.
REQ-027 A button already held through reset release SHALL produce exactly one press pulse (the accepted level starts at 0).
REQ-028 Reset asserted mid-RUNNING SHALL discard the prescaler fraction; no sec_pulse SHALL be emitted after reset release until RUNNING is re-entered.

Structure
REQ-029 Shared package stopwatch_pkg SHALL hold the state encoding constants IDLE, CLEAR and RUNNING, also used by the BCD counter.
REQ-030 One sub-module btn_cond (synchronizer, debounce, edge detect; parameter DB_CYCLES) SHALL be instantiated three times.

Verification (DIV=5, DB_CYCLES=4)
REQ-031 Reset release with no buttons -> state=3'b100, sec_pulse=0 for 50 cycles.
REQ-032 Startstop held 10 cycles from edge k -> state=3'b001 at edge k+7; sec_pulse every 5th cycle, high 1 cycle each.
REQ-033 Glitch of 3 cycles high on btn_startstop -> no state change.
REQ-034 Run 12 cycles, stop, wait 20, restart -> first pulse 3 cycles after restart (fraction kept).
REQ-035 In IDLE, clear and startstop pressed on the same cycle -> state 3'b010 for exactly 1 cycle, then 3'b100; prescaler and lap_hold = 0.
REQ-036 nrst pulsed low mid-RUNNING with a lap active -> all outputs at reset values at once; state IDLE after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//
// Purpose : Shared definitions between the stopwatch control block and the BCD
//           counter it drives. The mode encoding is one-hot so the counter can
//           decode each mode from a single bit.
//
// Contents: state_t      - one-hot mode encoding (IDLE / CLEAR / RUNNING)
//           STATE_W      - width of the mode bus
//           BTN_*        - index of each push-button in the button vector
//           is_legal_state() - true for the three legal one-hot codes
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'b100,
        CLEAR   = 3'b010,
        RUNNING = 3'b001
    } state_t;

    // Button vector ordering used inside the control block.
    localparam int BTN_STARTSTOP = 0;
    localparam int BTN_CLEAR     = 1;
    localparam int BTN_LAP       = 2;
    localparam int NUM_BTN       = 3;

    function automatic logic is_legal_state(input logic [STATE_W-1:0] code);
        return (code == IDLE) || (code == CLEAR) || (code == RUNNING);
    endfunction

endpackage

// File: rtl/btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond
//
// Purpose : Conditions one raw, asynchronous, active-high push-button into a
//           single-cycle press pulse: 2-flop synchronizer, then a debouncer
//           that only accepts a new level after DB_CYCLES consecutive cycles of
//           disagreement, then a rising-edge detector on the accepted level.
//
// Timing  : raw rise first sampled at edge k (and held) -> press is high in the
//           cycle after edge k+DB_CYCLES+2, so a consumer registering on press
//           acts at edge k+DB_CYCLES+3. Releases never produce a pulse.
//
// Ports   : clk   in  1  system clock, rising edge
//           nrst  in  1  asynchronous active-low reset
//           btn   in  1  raw button input
//           press out 1  one-cycle press pulse (registered)
// -----------------------------------------------------------------------------
module btn_cond #(
    parameter int DB_CYCLES = 200_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn,
    output logic press
);

    // Counter holds 0..DB_CYCLES-1; a one-cycle debounce still needs one bit.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;

            // Count consecutive disagreements; any agreement restarts at 0.
            if (sync_b != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end

            // Registered edge detect: one pulse per accepted 0->1 change.
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose : Control block of a stopwatch. Conditions three push-buttons, runs
//           the IDLE / CLEAR / RUNNING mode machine, divides the system clock
//           down to a one-second count strobe and manages the lap freeze flag.
//
// Ports   : clk            in  1  system clock, rising edge
//           nrst           in  1  asynchronous active-low reset
//           btn_startstop  in  1  raw start/stop button, active-high
//           btn_clear      in  1  raw clear button, active-high
//           btn_lap        in  1  raw lap button, active-high
//           state          out 3  one-hot mode to the BCD counter
//           sec_pulse      out 1  one-cycle count strobe
//           lap_hold       out 1  display freeze while counting continues
//           running        out 1  status LED, high exactly in RUNNING
//
// Handshake: there is no valid/ready pair here. sec_pulse is a strobe that the
//           BCD counter must consume in the single cycle it is high; state is
//           a level that is valid every cycle.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV       = 10_000_000,
    parameter int DB_CYCLES = 200_000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               btn_startstop,
    input  logic               btn_clear,
    input  logic               btn_lap,
    output logic [STATE_W-1:0] state,
    output logic               sec_pulse,
    output logic               lap_hold,
    output logic               running
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    state_t        st;
    logic [PW-1:0] presc;

    assign btn_raw[BTN_STARTSTOP] = btn_startstop;
    assign btn_raw[BTN_CLEAR]     = btn_clear;
    assign btn_raw[BTN_LAP]       = btn_lap;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_cond #(
            .DB_CYCLES (DB_CYCLES)
        ) u_btn_cond (
            .clk   (clk),
            .nrst  (nrst),
            .btn   (btn_raw[i]),
            .press (press[i])
        );
    end

    // Mode machine, prescaler, strobe and lap flag share one register block so
    // every output is a flop and they all move on the same edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st        <= IDLE;
            presc     <= '0;
            sec_pulse <= 1'b0;
            lap_hold  <= 1'b0;
            running   <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            case (st)
                IDLE: begin
                    // Clear wins over start when both arrive together. The
                    // prescaler holds here so a paused fraction survives.
                    if (press[BTN_CLEAR]) begin
                        st       <= CLEAR;
                        running  <= 1'b0;
                        presc    <= '0;
                        lap_hold <= 1'b0;
                    end else if (press[BTN_STARTSTOP]) begin
                        st      <= RUNNING;
                        running <= 1'b1;
                    end
                end

                RUNNING: begin
                    // The wrap (and its strobe) is skipped when stopping on
                    // the same edge; the prescaler then stays at its last
                    // value and the second completes right after restart.
                    if (presc == PRESC_LAST) begin
                        if (!press[BTN_STARTSTOP]) begin
                            presc     <= '0;
                            sec_pulse <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end

                    if (press[BTN_LAP]) begin
                        lap_hold <= ~lap_hold;
                    end

                    // Clear presses are ignored while counting.
                    if (press[BTN_STARTSTOP]) begin
                        st      <= IDLE;
                        running <= 1'b0;
                    end
                end

                CLEAR: begin
                    // One cycle only; any press landing here is dropped.
                    st       <= IDLE;
                    running  <= 1'b0;
                    presc    <= '0;
                    lap_hold <= 1'b0;
                end

                default: begin
                    // Illegal code (e.g. upset): fall back to IDLE.
                    st      <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with DIV=5, DB_CYCLES=4. A reference model steps on
// every rising edge, derives what the outputs must be after that edge from the
// button rules and pushes it into exp_q; a monitor on the falling edge pops and
// compares. Directed checks on top of that pin the key latencies to constants.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int DIV = 5;
  localparam int DB  = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CLEAR = 2;

  localparam logic [5:0] RESET_EXP = {3'b100, 1'b0, 1'b0, 1'b0};

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       btn_startstop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic [2:0] state;
  logic       sec_pulse;
  logic       lap_hold;
  logic       running;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIV       (DIV),
    .DB_CYCLES (DB)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .btn_startstop (btn_startstop),
    .btn_clear     (btn_clear),
    .btn_lap       (btn_lap),
    .state         (state),
    .sec_pulse     (sec_pulse),
    .lap_hold      (lap_hold),
    .running       (running)
  );

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;
  bit started = 1'b0;
  bit done = 1'b0;

  logic [5:0] exp_q[$];

  // ------------------------------------------------------------ reference model
  // Rules: each button is seen by the debouncer two edges after it is sampled;
  // the accepted level changes after DB consecutive disagreeing edges; a 0->1
  // acceptance at edge n is acted on by the mode machine at edge n+2.
  int m_mode = M_IDLE;
  int m_frac = 0;
  bit m_lap = 1'b0;
  bit m_pulse = 1'b0;
  int m_n = 0;
  bit hist0[3];
  bit hist1[3];
  bit acc[3];
  int run_len[3];
  int rise_n[3];

  function automatic logic [2:0] code_of(input int mode);
    if (mode == M_RUN) return 3'b001;
    if (mode == M_CLEAR) return 3'b010;
    return 3'b100;
  endfunction

  task model_reset();
    m_mode = M_IDLE;
    m_frac = 0;
    m_lap = 1'b0;
    m_pulse = 1'b0;
    for (int b = 0; b < 3; b++) begin
      hist0[b] = 1'b0;
      hist1[b] = 1'b0;
      acc[b] = 1'b0;
      run_len[b] = 0;
      rise_n[b] = -10;
    end
  endtask

  task model_step();
    bit pr[3];
    bit raw[3];
    bit syn;
    raw[0] = btn_startstop;
    raw[1] = btn_clear;
    raw[2] = btn_lap;
    m_n++;
    for (int b = 0; b < 3; b++) pr[b] = (rise_n[b] + 2 == m_n);

    m_pulse = 1'b0;
    if (m_mode == M_CLEAR) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (pr[1]) begin
        m_mode = M_CLEAR;
        m_frac = 0;
        m_lap = 1'b0;
      end else if (pr[0]) begin
        m_mode = M_RUN;
      end
    end else begin
      // Another clock of elapsed time; a full second completes unless the
      // watch is being stopped on this very clock.
      if (m_frac == DIV - 1) begin
        if (!pr[0]) begin
          m_frac = 0;
          m_pulse = 1'b1;
        end
      end else begin
        m_frac = m_frac + 1;
      end
      if (pr[2]) m_lap = !m_lap;
      if (pr[0]) m_mode = M_IDLE;
    end

    for (int b = 0; b < 3; b++) begin
      syn = hist1[b];
      hist1[b] = hist0[b];
      hist0[b] = raw[b];
      if (syn != acc[b]) begin
        run_len[b] = run_len[b] + 1;
        if (run_len[b] == DB) begin
          acc[b] = syn;
          run_len[b] = 0;
          if (syn) rise_n[b] = m_n;
        end
      end else begin
        run_len[b] = 0;
      end
    end

    exp_q.push_back({code_of(m_mode), m_pulse, m_lap, (m_mode == M_RUN)});
  endtask

  always @(negedge nrst) model_reset();

  always @(posedge clk) begin
    if (!nrst) exp_q.push_back(RESET_EXP);
    else model_step();
    started = 1'b1;
  end

  // ------------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] got;
    if (started && !done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (!nrst) e = RESET_EXP;
        got = {state, sec_pulse, lap_hold, running};
        if (got !== e) begin
          errors++;
          if (fail_prints < 30) begin
            fail_prints++;
            $display("FAIL scoreboard t=%0t got state=%b pulse=%b lap=%b run=%b exp state=%b pulse=%b lap=%b run=%b",
                     $time, got[5:3], got[2], got[1], got[0], e[5:3], e[2], e[1], e[0]);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ driver helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"}, {29'd0, state}, 32'h4);
    check({name, "_pulse"}, {31'd0, sec_pulse}, 32'h0);
    check({name, "_lap"}, {31'd0, lap_hold}, 32'h0);
    check({name, "_running"}, {31'd0, running}, 32'h0);
  endtask

  // ------------------------------------------------------------------ stimulus
  // Inputs change 1 time unit after a rising edge; a level set there is first
  // sampled at the next edge k, so tick(j+1) lands just after edge k+j.
  initial begin
    #2 nrst = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;

    // Quiet after reset.
    tick(50);
    check("idle_50", {29'd0, state}, 32'h4);

    // Start: RUNNING exactly at edge k+7, strobes at k+12 and k+17.
    btn_startstop = 1'b1;
    tick(7);
    check("start_k6_idle", {29'd0, state}, 32'h4);
    tick(1);
    check("start_k7_run", {29'd0, state}, 32'h1);
    check("start_k7_led", {31'd0, running}, 32'h1);
    tick(2);
    btn_startstop = 1'b0;
    tick(2);
    check("pulse_k11_low", {31'd0, sec_pulse}, 32'h0);
    tick(1);
    check("pulse_k12_high", {31'd0, sec_pulse}, 32'h1);
    tick(1);
    check("pulse_k13_low", {31'd0, sec_pulse}, 32'h0);
    tick(4);
    check("pulse_k17_high", {31'd0, sec_pulse}, 32'h1);
    tick(3);

    // Lap toggles on, then stop keeps it held in IDLE.
    btn_lap = 1'b1;
    tick(8);
    check("lap_on", {31'd0, lap_hold}, 32'h1);
    btn_lap = 1'b0;
    tick(10);
    btn_startstop = 1'b1;
    tick(6);
    btn_startstop = 1'b0;
    tick(10);
    check("stop_idle", {29'd0, state}, 32'h4);
    check("lap_held_idle", {31'd0, lap_hold}, 32'h1);

    // Three-cycle glitch is rejected.
    btn_startstop = 1'b1;
    tick(3);
    btn_startstop = 1'b0;
    tick(20);
    check("glitch_idle", {29'd0, state}, 32'h4);

    // Clear and start together from IDLE: one CLEAR cycle, then IDLE.
    btn_startstop = 1'b1;
    btn_clear = 1'b1;
    tick(8);
    check("both_clear", {29'd0, state}, 32'h2);
    check("both_lap0", {31'd0, lap_hold}, 32'h0);
    tick(1);
    check("both_then_idle", {29'd0, state}, 32'h4);
    btn_startstop = 1'b0;
    btn_clear = 1'b0;
    tick(15);

    // Run exactly 12 cycles from a cleared prescaler, pause, restart: the
    // kept fraction of 2 makes the first strobe land 3 cycles after restart.
    btn_startstop = 1'b1;
    tick(5);
    btn_startstop = 1'b0;
    tick(7);
    btn_startstop = 1'b1;
    tick(5);
    btn_startstop = 1'b0;
    tick(2);
    check("run12_still_run", {29'd0, state}, 32'h1);
    tick(1);
    check("run12_stopped", {29'd0, state}, 32'h4);
    tick(20);
    btn_startstop = 1'b1;
    tick(10);
    check("restart_run", {29'd0, state}, 32'h1);
    check("restart_r2_low", {31'd0, sec_pulse}, 32'h0);
    tick(1);
    check("restart_r3_high", {31'd0, sec_pulse}, 32'h1);
    btn_startstop = 1'b0;

    // Lap active while running, then an asynchronous reset mid-cycle with
    // start/stop held through the release.
    tick(2);
    btn_lap = 1'b1;
    tick(8);
    btn_lap = 1'b0;
    check("lap_before_reset", {31'd0, lap_hold}, 32'h1);
    tick(2);
    #2 nrst = 1'b0;
    btn_startstop = 1'b1;
    #1 check_reset_outputs("async_reset");
    tick(3);
    #1 nrst = 1'b1;
    #1 check_reset_outputs("after_release");
    tick(9);
    check("held_through_reset_run", {29'd0, state}, 32'h1);
    btn_startstop = 1'b0;
    tick(15);
    check("held_single_press", {29'd0, state}, 32'h1);
    btn_startstop = 1'b1;
    tick(6);
    btn_startstop = 1'b0;
    tick(10);

    // Random button activity, checked cycle by cycle against the model.
    for (int i = 0; i < 150; i++) begin
      btn_startstop = ($urandom_range(0, 2) == 0);
      btn_clear = ($urandom_range(0, 7) == 0);
      btn_lap = ($urandom_range(0, 3) == 0);
      tick($urandom_range(1, 9));
    end
    btn_startstop = 1'b0;
    btn_clear = 1'b0;
    btn_lap = 1'b0;
    tick(20);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
